// File: rtl/pfu_pkg.sv
// Shared definitions for pipelined_functional_unit: opcodes, per-opcode
// latency, width-generic result computation and the slot state encoding.
// Optional macro PFU_EXT_OPS_EN makes AND/SLL/SRL/SUB legal opcodes.
package pfu_pkg;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_PASS = 4'b1111;

  // Widest datapath the compute function supports; callers truncate.
  localparam int MAX_DATA_W = 64;
  localparam int LAT_W      = 3;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_WAIT = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_NONE, OP_OR, OP_ADD, OP_XOR, OP_SRA, OP_PASS: return 1'b1;
`ifdef PFU_EXT_OPS_EN
      OP_AND, OP_SLL, OP_SRL, OP_SUB:                  return 1'b1;
`endif
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic logic [LAT_W-1:0] op_latency(input logic [3:0] op);
    case (op)
      OP_OR, OP_XOR, OP_AND: return LAT_W'(1);
      OP_ADD, OP_SUB:        return LAT_W'(2);
      OP_SLL, OP_SRL:        return LAT_W'(3);
      OP_SRA:                return LAT_W'(4);
      default:               return LAT_W'(0);
    endcase
  endfunction

  // Operands arrive zero-extended to MAX_DATA_W; data_w is the real width.
  function automatic logic [MAX_DATA_W-1:0] op_compute(
    input logic [3:0]            op,
    input logic [MAX_DATA_W-1:0] lhs,
    input logic [MAX_DATA_W-1:0] rhs,
    input int                    data_w
  );
    logic [MAX_DATA_W-1:0]        one;
    logic [MAX_DATA_W-1:0]        mask;
    logic [MAX_DATA_W-1:0]        amt_mask;
    logic signed [MAX_DATA_W-1:0] lhs_s;
    logic [5:0]                   shamt;
    logic [MAX_DATA_W-1:0]        r;
    one      = {{(MAX_DATA_W-1){1'b0}}, 1'b1};
    mask     = (one << data_w) - one;
    amt_mask = MAX_DATA_W'(data_w - 1);
    shamt    = 6'(rhs & amt_mask);
    // Sign-extend lhs from bit data_w-1 so >>> replicates the real sign.
    lhs_s    = (|(lhs & (one << (data_w - 1)))) ? (lhs | ~mask) : lhs;
    case (op)
      OP_OR:   r = lhs | rhs;
      OP_ADD:  r = lhs + rhs;
      OP_XOR:  r = lhs ^ rhs;
      OP_AND:  r = lhs & rhs;
      OP_SUB:  r = lhs - rhs;
      OP_SLL:  r = lhs << shamt;
      OP_SRL:  r = lhs >> shamt;
      OP_SRA:  r = lhs_s >>> shamt;
      OP_PASS: r = rhs;
      default: r = '1;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/pfu_if.sv
// Dispatch-side issue port plus the wakeup and LSQ result buses of
// pipelined_functional_unit. master = dispatch/consumers, slave = the unit.
interface pfu_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int ROB_W  = 6,
  parameter int DEPTH  = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic [3:0]        alu_control;
  logic              alu_src;
  logic              is_for_lsq;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rs1_value;
  logic [DATA_W-1:0] rs2_value;
  logic [TAG_W-1:0]  tag_to_output;
  logic [ROB_W-1:0]  rob_index;
  logic              illegal_op;
  logic [OCC_W-1:0]  occupancy;

  logic              wakeup_valid;
  logic              wakeup_ready;
  logic [TAG_W-1:0]  wakeup_tag;
  logic [ROB_W-1:0]  wakeup_rob_index;
  logic [DATA_W-1:0] wakeup_value;

  logic              lsq_valid;
  logic              lsq_ready;
  logic [ROB_W-1:0]  lsq_rob_index;
  logic [DATA_W-1:0] lsq_value;

  modport master (
    output flush, issue_valid, alu_control, alu_src, is_for_lsq, imm,
           rs1_value, rs2_value, tag_to_output, rob_index,
           wakeup_ready, lsq_ready,
    input  issue_ready, illegal_op, occupancy,
           wakeup_valid, wakeup_tag, wakeup_rob_index, wakeup_value,
           lsq_valid, lsq_rob_index, lsq_value
  );

  modport slave (
    input  flush, issue_valid, alu_control, alu_src, is_for_lsq, imm,
           rs1_value, rs2_value, tag_to_output, rob_index,
           wakeup_ready, lsq_ready,
    output issue_ready, illegal_op, occupancy,
           wakeup_valid, wakeup_tag, wakeup_rob_index, wakeup_value,
           lsq_valid, lsq_rob_index, lsq_value
  );
endinterface

// File: rtl/pfu_oldest_select.sv
// Oldest-first picker: older[i][j]=1 means slot i was accepted before slot j.
// Grants the requester that is older than every other requester (one-hot).
module pfu_oldest_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            req,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant
);

  // A request wins unless some other requester is older than it.
  always_comb begin
    // NOTE: every bit gets a value before the loop, so no latch can be inferred.
    grant = req;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && req[j] && !older[i][j]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipelined_functional_unit.sv
// Multi-slot ALU functional unit: DEPTH in-flight ops with per-opcode
// latency, oldest-first retirement onto the wakeup and LSQ buses.
// Optional macro PFU_EXT_OPS_EN (see pfu_pkg) enables AND/SLL/SRL/SUB.
module pipelined_functional_unit
  import pfu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int ROB_W  = 6,
  parameter int DEPTH  = 4
) (
  input  logic clk,
  input  logic reset_n,
  pfu_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  slot_state_e                state [DEPTH];
  logic [LAT_W-1:0]           count [DEPTH];
  logic [DATA_W-1:0]          value [DEPTH];
  logic [TAG_W-1:0]           tag   [DEPTH];
  logic [ROB_W-1:0]           rob   [DEPTH];
  logic [DEPTH-1:0]           to_lsq;
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic                       illegal_q;
  logic                       lock_w, lock_l;
  logic [DEPTH-1:0]           lock_w_sel, lock_l_sel;

  logic [OCC_W-1:0]  occ;
  logic [IDX_W-1:0]  free_idx;
  logic              op_ok, accept, illegal_hit;
  logic [DATA_W-1:0] rhs, result;
  logic [LAT_W-1:0]  lat;
  logic [DEPTH-1:0]  done_vec, pick_w, pick_l, sel_w, sel_l;
  logic              hs_w, hs_l;
  logic [DATA_W-1:0] w_value, l_value;
  logic [TAG_W-1:0]  w_tag;
  logic [ROB_W-1:0]  w_rob, l_rob;

  // Occupancy, lowest free slot and DONE vector from registered slot state.
  always_comb begin
    occ      = '0;
    free_idx = '0;
    done_vec = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state[i] != SLOT_FREE) occ = occ + OCC_W'(1);
      else                       free_idx = IDX_W'(i);
      done_vec[i] = (state[i] == SLOT_DONE);
    end
  end

  assign bus.occupancy   = occ;
  assign bus.issue_ready = reset_n && (occ != OCC_W'(DEPTH));
  assign bus.illegal_op  = illegal_q;

  assign op_ok       = op_legal(bus.alu_control);
  assign accept      = bus.issue_valid && bus.issue_ready && !bus.flush && op_ok;
  assign illegal_hit = bus.issue_valid && bus.issue_ready && !bus.flush && !op_ok;
  assign rhs         = bus.alu_src ? bus.imm : bus.rs2_value;
  assign lat         = op_latency(bus.alu_control);
  assign result      = DATA_W'(op_compute(bus.alu_control, MAX_DATA_W'(bus.rs1_value),
                                          MAX_DATA_W'(rhs), DATA_W));

  pfu_oldest_select #(.DEPTH(DEPTH)) u_sel_wakeup (
    .req   (done_vec & ~to_lsq),
    .older (older),
    .grant (pick_w)
  );

  pfu_oldest_select #(.DEPTH(DEPTH)) u_sel_lsq (
    .req   (done_vec & to_lsq),
    .older (older),
    .grant (pick_l)
  );

  // A stalled offer stays locked so the bus never switches slot mid-offer.
  assign sel_w = lock_w ? lock_w_sel : pick_w;
  assign sel_l = lock_l ? lock_l_sel : pick_l;

  assign bus.wakeup_valid = reset_n && !bus.flush && (|sel_w);
  assign bus.lsq_valid    = reset_n && !bus.flush && (|sel_l);
  assign hs_w             = bus.wakeup_valid && bus.wakeup_ready;
  assign hs_l             = bus.lsq_valid && bus.lsq_ready;

  // One-hot output mux for each bus.
  always_comb begin
    w_value = '0;
    w_tag   = '0;
    w_rob   = '0;
    l_value = '0;
    l_rob   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_w[i]) begin
        w_value = w_value | value[i];
        w_tag   = w_tag | tag[i];
        w_rob   = w_rob | rob[i];
      end
      if (sel_l[i]) begin
        l_value = l_value | value[i];
        l_rob   = l_rob | rob[i];
      end
    end
  end

  assign bus.wakeup_value     = bus.wakeup_valid ? w_value : '0;
  assign bus.wakeup_tag       = bus.wakeup_valid ? w_tag   : '0;
  assign bus.wakeup_rob_index = bus.wakeup_valid ? w_rob   : '0;
  assign bus.lsq_value        = bus.lsq_valid    ? l_value : '0;
  assign bus.lsq_rob_index    = bus.lsq_valid    ? l_rob   : '0;

  // Slot state machines, output locks and the illegal-op pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= only, so every block sees pre-edge values.
    if (!reset_n || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        state[i] <= SLOT_FREE;
        count[i] <= '0;
      end
      illegal_q  <= 1'b0;
      lock_w     <= 1'b0;
      lock_l     <= 1'b0;
      lock_w_sel <= '0;
      lock_l_sel <= '0;
    end else begin
      illegal_q  <= illegal_hit;
      lock_w     <= bus.wakeup_valid && !bus.wakeup_ready;
      lock_l     <= bus.lsq_valid && !bus.lsq_ready;
      lock_w_sel <= sel_w;
      lock_l_sel <= sel_l;
      for (int i = 0; i < DEPTH; i++) begin
        case (state[i])
          SLOT_WAIT: begin
            if (count[i] <= LAT_W'(1)) state[i] <= SLOT_DONE;
            else                       count[i] <= count[i] - LAT_W'(1);
          end
          SLOT_DONE: begin
            if ((hs_w && sel_w[i]) || (hs_l && sel_l[i])) state[i] <= SLOT_FREE;
          end
          default: ;
        endcase
      end
      if (accept) begin
        state[free_idx] <= (lat == '0) ? SLOT_DONE : SLOT_WAIT;
        count[free_idx] <= lat;
      end
    end
  end

  // Slot payload and age matrix: the new entry is younger than everyone.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; it is only read while its slot is non-FREE.
    if (accept) begin
      value[free_idx]  <= result;
      tag[free_idx]    <= bus.tag_to_output;
      rob[free_idx]    <= bus.rob_index;
      to_lsq[free_idx] <= bus.is_for_lsq;
      older[free_idx]  <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != int'(free_idx)) older[j][free_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_functional_unit.sv
// Self-checking bench for pipelined_functional_unit: a queue-based model of
// in-flight ops in accept order, checked every cycle, plus directed literals.
module tb_pipelined_functional_unit;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int ROB_W  = 6;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pfu_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .ROB_W(ROB_W), .DEPTH(DEPTH)) bus ();

  pipelined_functional_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W), .ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          seq;
    logic [5:0]  tag;
    logic [5:0]  rob;
    bit          lsq;
    logic [31:0] value;
    int          rdy;
  } entry_t;

  entry_t mq[$];
  int     held_w = -1, held_l = -1;
  int     seq_ctr = 0;
  int     cyc = 0;
  bit     m_ill = 0;
  bit     known = 0;

  function automatic bit ref_legal(input logic [3:0] op);
    if (op == 4'b0000 || op == 4'b0001 || op == 4'b0010 || op == 4'b0011 ||
        op == 4'b1011 || op == 4'b1111) return 1;
`ifdef PFU_EXT_OPS_EN
    if (op == 4'b0111 || op == 4'b0100 || op == 4'b0101 || op == 4'b1010) return 1;
`endif
    return 0;
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0011, 4'b0111: return 1;
      4'b0010, 4'b1010:          return 2;
      4'b0100, 4'b0101:          return 3;
      4'b1011:                   return 4;
      default:                   return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_value(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0111: return a & b;
      4'b1010: return a - b;
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b1011: return sa >>> b[4:0];
      4'b1111: return b;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Index of the entry a bus must present: the held one, else the oldest done.
  function automatic int offer(input bit lsq_bus);
    int held;
    held = lsq_bus ? held_l : held_w;
    for (int i = 0; i < mq.size(); i++) begin
      if (held >= 0) begin
        if (mq[i].seq == held) return i;
      end else if (mq[i].lsq == lsq_bus && cyc >= mq[i].rdy) return i;
    end
    return -1;
  endfunction

  task automatic remove_seq(input int s);
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].seq == s) begin
        mq.delete(i);
        break;
      end
    end
  endtask

  // Compare process: check outputs for this cycle, then advance the model.
  always @(negedge clk) begin
    int ew, el, hs_w, hs_l;
    bit full_now;
    entry_t e;
    if (!reset_n) begin
      check("rst_issue_ready", bus.issue_ready, 0);
      check("rst_wakeup_valid", bus.wakeup_valid, 0);
      check("rst_lsq_valid", bus.lsq_valid, 0);
      check("rst_wakeup_data", {bus.wakeup_value, bus.wakeup_tag, bus.wakeup_rob_index}, 0);
      check("rst_lsq_data", {bus.lsq_value, bus.lsq_rob_index}, 0);
      mq.delete();
      held_w = -1;
      held_l = -1;
      m_ill  = 0;
      known  = 1;
    end else if (known) begin
      ew = bus.flush ? -1 : offer(0);
      el = bus.flush ? -1 : offer(1);
      check("occupancy", bus.occupancy, mq.size());
      check("issue_ready", bus.issue_ready, mq.size() < DEPTH);
      check("illegal_op", bus.illegal_op, m_ill);
      check("wakeup_valid", bus.wakeup_valid, ew >= 0);
      check("lsq_valid", bus.lsq_valid, el >= 0);
      if (ew >= 0) begin
        e = mq[ew];
        check("wakeup_tag", bus.wakeup_tag, e.tag);
        check("wakeup_rob", bus.wakeup_rob_index, e.rob);
        check("wakeup_value", bus.wakeup_value, e.value);
      end else begin
        check("wakeup_idle_data", {bus.wakeup_value, bus.wakeup_tag, bus.wakeup_rob_index}, 0);
      end
      if (el >= 0) begin
        e = mq[el];
        check("lsq_rob", bus.lsq_rob_index, e.rob);
        check("lsq_value", bus.lsq_value, e.value);
      end else begin
        check("lsq_idle_data", {bus.lsq_value, bus.lsq_rob_index}, 0);
      end

      if (bus.flush) begin
        mq.delete();
        held_w = -1;
        held_l = -1;
        m_ill  = 0;
      end else begin
        full_now = (mq.size() >= DEPTH);
        hs_w   = (ew >= 0 && bus.wakeup_ready) ? mq[ew].seq : -1;
        hs_l   = (el >= 0 && bus.lsq_ready) ? mq[el].seq : -1;
        held_w = (ew >= 0 && !bus.wakeup_ready) ? mq[ew].seq : -1;
        held_l = (el >= 0 && !bus.lsq_ready) ? mq[el].seq : -1;
        if (hs_w >= 0) remove_seq(hs_w);
        if (hs_l >= 0) remove_seq(hs_l);
        m_ill = 0;
        if (bus.issue_valid && !full_now) begin
          if (ref_legal(bus.alu_control)) begin
            e.seq   = seq_ctr++;
            e.tag   = bus.tag_to_output;
            e.rob   = bus.rob_index;
            e.lsq   = bus.is_for_lsq;
            e.value = ref_value(bus.alu_control, bus.rs1_value,
                                bus.alu_src ? bus.imm : bus.rs2_value);
            e.rdy   = cyc + 1 + ref_lat(bus.alu_control);
            mq.push_back(e);
          end else begin
            m_ill = 1;
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic src, input logic lsq,
                       input logic [5:0] tag, input logic [5:0] rob);
    bus.issue_valid   = 1'b1;
    bus.alu_control   = op;
    bus.rs1_value     = rs1;
    bus.rs2_value     = rs2;
    bus.imm           = imm;
    bus.alu_src       = src;
    bus.is_for_lsq    = lsq;
    bus.tag_to_output = tag;
    bus.rob_index     = rob;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] legal_ops[$];
    logic [3:0] op;
    legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1011, 4'b1111};
`ifdef PFU_EXT_OPS_EN
    legal_ops.push_back(4'b0111);
    legal_ops.push_back(4'b0100);
    legal_ops.push_back(4'b0101);
    legal_ops.push_back(4'b1010);
`endif
    idle();
    drive(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    bus.issue_valid  = 1'b0;
    bus.wakeup_ready = 1'b1;
    bus.lsq_ready    = 1'b1;
    reset_n          = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_issue_ready", bus.issue_ready, 1);
    check("post_reset_occupancy", bus.occupancy, 0);
    tick();

    // Single ADD: 5+7 visible only two cycles after the accept cycle's successor.
    drive(4'b0010, 5, 7, 0, 0, 0, 6'd1, 6'd9);
    tick();
    idle();
    @(negedge clk); check("add_t1_valid", bus.wakeup_valid, 0);
    @(negedge clk); check("add_t2_valid", bus.wakeup_valid, 0);
    @(negedge clk);
    check("add_t3_valid", bus.wakeup_valid, 1);
    check("add_t3_value", bus.wakeup_value, 12);
    check("add_t3_tag", bus.wakeup_tag, 1);
    check("add_t3_rob", bus.wakeup_rob_index, 9);
    tick();

    // Out-of-order: SRA then OR; OR wakes first.
    drive(4'b1011, 32'h8000_0000, 0, 4, 1, 0, 6'd2, 6'd2);
    tick();
    drive(4'b0001, 1, 2, 0, 0, 0, 6'd3, 6'd3);
    tick();
    idle();
    @(negedge clk); check("ooo_t2_valid", bus.wakeup_valid, 0);
    @(negedge clk);
    check("ooo_or_tag", bus.wakeup_tag, 3);
    check("ooo_or_value", bus.wakeup_value, 3);
    @(negedge clk); check("ooo_t4_valid", bus.wakeup_valid, 0);
    @(negedge clk);
    check("ooo_sra_tag", bus.wakeup_tag, 2);
    check("ooo_sra_value", bus.wakeup_value, 32'hF800_0000);
    tick();

    // Backpressure: four held, retire in accept order on release.
    bus.wakeup_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(4'b0010, k, 1, 0, 0, 0, 6'(10 + k), 6'(10 + k));
      tick();
    end
    drive(4'b0011, 6, 3, 0, 0, 0, 6'd13, 6'd13);
    tick();
    idle();
    @(negedge clk);
    check("bp_full_issue_ready", bus.issue_ready, 0);
    check("bp_full_occupancy", bus.occupancy, 4);
    check("bp_stalled_tag", bus.wakeup_tag, 10);
    tick();
    tick();
    bus.wakeup_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_order_tag", bus.wakeup_tag, 10 + k);
      if (k == 1) check("bp_reuse_issue_ready", bus.issue_ready, 1);
    end
    tick();

    // Dual bus: one wakeup and one LSQ result handshake together.
    bus.wakeup_ready = 1'b0;
    bus.lsq_ready    = 1'b0;
    drive(4'b0001, 32'hF0, 32'h0F, 0, 0, 0, 6'd5, 6'd5);
    tick();
    drive(4'b1111, 0, 0, 32'h100, 1, 1, 6'd6, 6'd20);
    tick();
    idle();
    @(negedge clk);
    check("dual_both_valid", {bus.wakeup_valid, bus.lsq_valid}, 2'b11);
    check("dual_lsq_value", bus.lsq_value, 32'h100);
    check("dual_lsq_rob", bus.lsq_rob_index, 20);
    check("dual_occupancy", bus.occupancy, 2);
    tick();
    bus.wakeup_ready = 1'b1;
    bus.lsq_ready    = 1'b1;
    @(negedge clk); check("dual_hs_valid", {bus.wakeup_valid, bus.lsq_valid}, 2'b11);
    @(negedge clk); check("dual_after_occupancy", bus.occupancy, 0);
    tick();

    // Flush with three in flight, then an illegal opcode.
    bus.wakeup_ready = 1'b0;
    bus.lsq_ready    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, 0, 0, 32'(k + 1), 1, k[0], 6'(30 + k), 6'(30 + k));
      tick();
    end
    idle();
    @(negedge clk); check("fl_pre_occupancy", bus.occupancy, 3);
    tick();
    bus.flush = 1'b1;
    @(negedge clk);
    check("fl_cycle_valids", {bus.wakeup_valid, bus.lsq_valid}, 0);
    tick();
    bus.flush = 1'b0;
    @(negedge clk); check("fl_next_occupancy", bus.occupancy, 0);
    tick();
    drive(4'b1111, 0, 0, 9, 1, 0, 6'd33, 6'd33);
    tick();
    drive(4'b0110, 1, 1, 0, 0, 0, 6'd34, 6'd34);
    tick();
    idle();
    @(negedge clk);
    check("ill_pulse", bus.illegal_op, 1);
    check("ill_occupancy", bus.occupancy, 1);
    tick();
    @(negedge clk);
    check("ill_pulse_end", bus.illegal_op, 0);
    check("ill_occupancy_hold", bus.occupancy, 1);
    bus.wakeup_ready = 1'b1;
    bus.lsq_ready    = 1'b1;
    tick();
    tick();

    // Reset mid-SRA: nothing stale afterwards.
    drive(4'b1011, 32'h8000_0000, 0, 1, 1, 0, 6'd40, 6'd40);
    tick();
    idle();
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_issue_ready", bus.issue_ready, 0);
    check("rst_mid_valids", {bus.wakeup_valid, bus.lsq_valid}, 0);
    tick();
    @(negedge clk); check("rst_mid_occupancy", bus.occupancy, 0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_rel_issue_ready", bus.issue_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_stale_wakeup", bus.wakeup_valid, 0);
    end
    tick();

`ifdef PFU_EXT_OPS_EN
    drive(4'b1010, 3, 5, 0, 0, 0, 6'd41, 6'd41);
    tick();
    idle();
    @(negedge clk); check("sub_t1_valid", bus.wakeup_valid, 0);
    @(negedge clk); check("sub_t2_valid", bus.wakeup_valid, 0);
    @(negedge clk);
    check("sub_t3_valid", bus.wakeup_valid, 1);
    check("sub_value", bus.wakeup_value, 32'hFFFF_FFFE);
    tick();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset_n          = ($urandom_range(0, 999) >= 3);
      bus.wakeup_ready = ($urandom_range(0, 99) < 70);
      bus.lsq_ready    = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 19) == 0 && mq.size() < DEPTH) op = 4'($urandom_range(0, 15));
      else op = legal_ops[$urandom_range(0, legal_ops.size() - 1)];
      drive(op, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom));
      bus.issue_valid = ($urandom_range(0, 99) < 60);
      bus.flush       = ($urandom_range(0, 99) < 2);
      tick();
    end
    idle();
    reset_n          = 1'b1;
    bus.wakeup_ready = 1'b1;
    bus.lsq_ready    = 1'b1;
    repeat (20) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
